reg_file_8x16: RTL and testbench
================================

# reg_file_8x16

Eight-entry, 16-bit general-purpose register file for the 16-bit single-cycle core.
- Consumes the write side produced by the datapath and presents the read side to the ALU operand muxes: two combinational read ports.
- Includes a handshaked dump engine that streams all eight registers, in order, to a debug/trace sink.
- Sits between the decode stage (addresses) and the ALU/write-back logic.

## Interface
Parameters:
- DEPTH, 8: number of registers; must be 8 (3-bit addresses).
- WIDTH, 16: register width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- we  in  1  write enable.
- waddr  in  3  write address.
- wdata  in  16  write data.
- raddr_a  in  3  read port A address.
- rdata_a  out  16  read port A data (combinational).
- raddr_b  in  3  read port B address.
- rdata_b  out  16  read port B data (combinational).
- dump_start  in  1  request a full register dump.
- dump_valid  out  1  dump word present.
- dump_ready  in  1  sink accepts the dump word.
- dump_addr  out  3  index of the current dump word.
- dump_data  out  16  contents of the current dump word.
- dump_busy  out  1  dump in progress.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- Storage: 8 × 16-bit flops.
  - If we=1 at an edge, regs[waddr] <= wdata.
  - All registers are writable; no hardwired zero.
- Read ports:
  - rdata_x = regs[raddr_x], combinational.
  - Both ports may address the same register.
- Dump FSM, states IDLE and SEND:
  - IDLE: dump_valid=0, dump_busy=0. If dump_start=1, idx<=0 and go to SEND.
  - SEND: dump_valid=1, dump_busy=1, dump_addr=idx, dump_data=regs[idx] (storage value, never bypassed).
  - In SEND, when dump_valid&&dump_ready at an edge:
    - If idx=7: go to IDLE and assert dump_done for the next cycle only.
    - Otherwise: idx<=idx+1.
  - dump_start is ignored while in SEND.
  - dump_start in the same cycle dump_done is high starts a new dump.
- A write to regs[idx] while that word is pending (valid, not yet accepted) updates dump_data on the following cycle.
  - The sink receives whatever value is present at acceptance.
- Writes and reads proceed normally during a dump; the dump never stalls the datapath.

## Timing
- Reset values: all regs=0x0000; FSM=IDLE; idx=0; dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0. rdata_a and rdata_b read 0x0000 after reset.
- rst overrides we, dump_start and dump_ready in the same cycle.
- Reset mid-dump: return to IDLE; no dump_done pulse; the partial dump is abandoned.
- Write latency: data written at edge N is visible on rdata_x after edge N (one cycle), unless bypass is enabled.
- Dump latency:
  - dump_start at edge N gives dump_valid=1 with dump_addr=0 after edge N.
  - With dump_ready held at 1, one word per cycle: 8 cycles, then dump_done high in the ninth cycle after start.
- dump_valid may not drop while a word is pending; dump_addr and dump_data stay stable except for the write-update rule above.

## Configuration
- Macro RF_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding. If we=1 and waddr==raddr_x, then rdata_x=wdata combinationally, for each port independently. The dump port is never bypassed.
- Undefined: rdata_x always reflects stored contents; a write is visible from the next cycle.

## Test plan
- Reset, then write 0x1234 to r3 and 0xBEEF to r7. Read A=r3, B=r7 next cycle: 0x1234 / 0xBEEF. Read r0: 0x0000.
- Bypass: we=1, waddr=5, wdata=0xA5A5, raddr_a=5 in the same cycle.
  - With RF_BYPASS_EN: rdata_a=0xA5A5 that cycle.
  - Without it: old value that cycle, 0xA5A5 the next.
- Registers loaded with 0x0100+i, dump_start pulse, dump_ready=1 constantly:
  - Eight consecutive words, addresses 0..7, data 0x0100..0x0107.
  - dump_done is a single one-cycle pulse after address 7.
- Backpressure: dump_ready toggling 1,0,0,1…
  - Each word is held stable while dump_ready=0; no word is skipped or duplicated.
  - dump_start asserted mid-dump has no effect.
- Write r2=0xCAFE while dump_addr=2 is pending with dump_ready=0: dump_data becomes 0xCAFE next cycle and is accepted as 0xCAFE.
- rst asserted while dump_addr=4: next cycle dump_valid=0, dump_busy=0, no dump_done, all registers read 0x0000.

Source files
------------

// File: rtl/reg_file_8x16.sv
// Purpose: 8x16 register file with two combinational read ports and a handshaked dump engine.
// Latency: reads are combinational; writes are visible the cycle after the edge (same cycle with RF_BYPASS_EN).
// Backpressure: a dump word is held stable while dump_ready=0; the datapath is never stalled.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   we, waddr, wdata             : write port
//   raddr_a/rdata_a, raddr_b/rdata_b : combinational read ports
//   dump_start                   : start streaming r0..r7 (ignored while a dump runs)
//   dump_valid/dump_ready        : dump handshake; dump_addr/dump_data carry the word
//   dump_busy                    : dump in progress; dump_done pulses after r7 is accepted
// Build option: RF_BYPASS_EN enables same-cycle write-to-read forwarding on ports A and B.
module reg_file_8x16 #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [2:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [2:0]       dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  typedef enum logic {IDLE, SEND} state_t;

  logic [WIDTH-1:0] regs [DEPTH];
  state_t           state;
  state_t           state_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic             done_nxt;

  // Storage, dump FSM state and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      state     <= IDLE;
      idx       <= 3'd0;
      dump_done <= 1'b0;
    end else begin
      if (we) begin
        regs[waddr] <= wdata;
      end
      state     <= state_nxt;
      idx       <= idx_nxt;
      dump_done <= done_nxt;
    end
  end

  // Dump FSM next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    done_nxt   = 1'b0;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nxt = SEND;
          idx_nxt   = 3'd0;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (idx == 3'd7) begin
            // Park idx at 0 so dump_addr idles at its reset value.
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  // The dump port always shows stored contents, so a write to the pending
  // word shows up here one cycle later.
  assign dump_addr = idx;
  assign dump_data = regs[idx];

`ifdef RF_BYPASS_EN
  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
`else
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
`endif

endmodule

// File: tb/tb_reg_file_8x16.sv
module tb_reg_file_8x16;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [15:0] rdata_a;
  logic [2:0]  raddr_b;
  logic [15:0] rdata_b;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [2:0]  dump_addr;
  logic [15:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  reg_file_8x16 #(.DEPTH(8), .WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr_a    (raddr_a),
    .rdata_a    (rdata_a),
    .raddr_b    (raddr_b),
    .rdata_b    (rdata_b),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents as a plain array, and the dump as
  // "which word the sink is owed next" plus a count of words delivered.
  logic [15:0] mdl [8];
  bit          m_active;
  int          m_word;
  bit          m_done;
  bit          m_fresh_rst;
  bit          chk_en;

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
`ifdef RF_BYPASS_EN
    if (we && (waddr == a)) return wdata;
`endif
    return mdl[a];
  endfunction

  task automatic compare();
    check("rdata_a", 32'(rdata_a), 32'(exp_rd(raddr_a)));
    check("rdata_b", 32'(rdata_b), 32'(exp_rd(raddr_b)));
    check("dump_valid", 32'(dump_valid), 32'(m_active));
    check("dump_busy", 32'(dump_busy), 32'(m_active));
    check("dump_done", 32'(dump_done), 32'(m_done));
    if (m_active) begin
      check("dump_addr", 32'(dump_addr), 32'(m_word));
      check("dump_data", 32'(dump_data), 32'(mdl[m_word]));
    end else if (m_fresh_rst) begin
      check("dump_addr_rst", 32'(dump_addr), 32'd0);
    end
  endtask

  task automatic update_model();
    bit done_n;
    done_n = 1'b0;
    if (rst) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      m_active    = 1'b0;
      m_word      = 0;
      m_done      = 1'b0;
      m_fresh_rst = 1'b1;
      return;
    end
    if (m_active) begin
      if (dump_ready) begin
        // Word m_word delivered; the eighth delivery ends the dump.
        if (m_word + 1 == 8) begin
          m_active = 1'b0;
          done_n   = 1'b1;
        end else begin
          m_word = m_word + 1;
        end
      end
    end else if (dump_start) begin
      m_active    = 1'b1;
      m_word      = 0;
      m_fresh_rst = 1'b0;
    end
    m_done = done_n;
    if (we) mdl[waddr] = wdata;
  endtask

  // One cycle: inputs already set at the negedge; check, clock, update model.
  task automatic step();
    #1;
    if (chk_en) compare();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 0; we = 0; waddr = 0; wdata = 0;
    dump_start = 0; dump_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_en = 0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    m_active = 0; m_word = 0; m_done = 0; m_fresh_rst = 1;
    idle_in();
    raddr_a = 0; raddr_b = 0;
    @(negedge clk);
    rst = 1;
    step();
    step();
    rst = 0;
    chk_en = 1;

    // Reset state on every address pair.
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(7 - i);
      step();
    end

    // Basic writes and reads.
    we = 1; waddr = 3; wdata = 16'h1234; step();
    waddr = 7; wdata = 16'hBEEF; step();
    we = 0; raddr_a = 3; raddr_b = 7; step();
    check("r3_direct", 32'(rdata_a), 32'h1234);
    check("r7_direct", 32'(rdata_b), 32'hBEEF);
    raddr_a = 0; raddr_b = 3; step();
    check("r0_zero", 32'(rdata_a), 32'h0000);

    // Same-cycle write and read of r5.
    we = 1; waddr = 5; wdata = 16'hA5A5; raddr_a = 5; raddr_b = 5;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_same", 32'(rdata_a), 32'hA5A5);
`else
    check("nobypass_same", 32'(rdata_a), 32'h0000);
`endif
    step();
    we = 0; step();
    check("r5_next", 32'(rdata_a), 32'hA5A5);

    // Full dump with ready held high.
    for (int i = 0; i < 8; i++) begin
      we = 1; waddr = 3'(i); wdata = 16'h0100 + 16'(i); step();
    end
    we = 0; dump_start = 1; dump_ready = 1; step();
    dump_start = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("seq_addr", 32'(dump_addr), 32'(i));
      check("seq_data", 32'(dump_data), 32'h0100 + 32'(i));
      check("seq_no_done", 32'(dump_done), 32'd0);
      step();
    end
    #1; check("seq_done", 32'(dump_done), 32'd1);
    dump_ready = 0; step();
    #1; check("seq_done_once", 32'(dump_done), 32'd0);

    // Backpressure 1,0,0,1... with dump_start held high mid-dump.
    dump_start = 1; step();
    for (int c = 0; c < 40 && (m_active || c == 0); c++) begin
      dump_ready = ((c % 3) == 0);
      dump_start = (c > 2);
      step();
    end
    check("bp_finished", 32'(m_active), 32'd0);
    idle_in(); step();

    // Write the pending word while it is stalled.
    dump_start = 1; step();
    dump_start = 0;
    for (int c = 0; c < 20 && m_word != 2; c++) begin
      dump_ready = 1; step();
    end
    dump_ready = 0; we = 1; waddr = 2; wdata = 16'hCAFE; step();
    we = 0; #1;
    check("cafe_addr", 32'(dump_addr), 32'd2);
    check("cafe_data", 32'(dump_data), 32'hCAFE);
    step();
    dump_ready = 1; step();
    #1; check("cafe_advanced", 32'(dump_addr), 32'd3);

    // Reset mid-dump at word 4.
    for (int c = 0; c < 20 && m_word != 4; c++) step();
    check("reached_w4", 32'(dump_addr), 32'd4);
    rst = 1; step();
    rst = 0; dump_ready = 1;
    #1;
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_busy", 32'(dump_busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(i); step();
    end

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(63) == 0);
      we         = $urandom_range(1);
      waddr      = 3'($urandom_range(7));
      wdata      = 16'($urandom);
      raddr_a    = 3'($urandom_range(7));
      raddr_b    = 3'($urandom_range(7));
      dump_start = ($urandom_range(7) == 0);
      dump_ready = $urandom_range(1);
      step();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
